// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the program-counter stage.
package cpu_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_ALIGN = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } seqState_t;

    // A register jump target must land on a word boundary.
    function automatic logic isWordAligned(input logic [PC_W-1:0] addr);
        return addr[INSTR_ALIGN-1:0] == '0;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC select for a retiring, non-trapping, non-halting instruction.
module pc_target_mux
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] pcPlus4,
    input  logic [PC_W-1:0] shiftedOffset,
    input  logic            branch,
    input  logic            branchNe,
    input  logic            zero,
    input  logic            jump,
    input  logic [25:0]     jumpIndex,
    input  logic            jumpReg,
    input  logic [PC_W-1:0] regTarget,
    output logic [PC_W-1:0] nextPc
);

    logic branchTaken;

    // BNE inverts the sense of the zero flag.
    assign branchTaken = branch && (zero ^ branchNe);

    always_comb begin
        nextPc = pcPlus4;
        if (jumpReg)
            nextPc = regTarget;
        else if (jump)
            nextPc = {pcPlus4[31:28], jumpIndex, 2'b00};
        else if (branchTaken)
            nextPc = pcPlus4 + shiftedOffset;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with fetch handshake, stall, halt, misaligned-JR trap and retire counter.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [PC_W-1:0]  ShiftedOffset,
    input  logic             Branch,
    input  logic             BranchNe,
    input  logic             Zero,
    input  logic             Jump,
    input  logic [25:0]      JumpIndex,
    input  logic             JumpReg,
    input  logic [PC_W-1:0]  RegTarget,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             FetchReady,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PCPlus4,
    output logic             FetchValid,
    output logic             Halted,
    output logic             AddrError,
    output logic [PC_W-1:0]  BadAddr,
    output logic [CNT_W-1:0] InstrCount
);

    seqState_t       state, stateNext;
    logic [PC_W-1:0] targetPc, pcNext;
    logic            retire, cntInc, trap;

    assign PCPlus4 = PC + 32'd4;
    assign retire  = (state == ST_RUN) && FetchReady && !Stall;

    pc_target_mux uTargetMux (
        .pcPlus4      (PCPlus4),
        .shiftedOffset(ShiftedOffset),
        .branch       (Branch),
        .branchNe     (BranchNe),
        .zero         (Zero),
        .jump         (Jump),
        .jumpIndex    (JumpIndex),
        .jumpReg      (JumpReg),
        .regTarget    (RegTarget),
        .nextPc       (targetPc)
    );

    // Trap outranks halt, which outranks any PC redirect.
    always_comb begin
        stateNext = state;
        pcNext    = PC;
        cntInc    = 1'b0;
        trap      = 1'b0;
        if (retire) begin
            if (JumpReg && !isWordAligned(RegTarget)) begin
                stateNext = ST_ERROR;
                trap      = 1'b1;
            end else if (Halt) begin
                stateNext = ST_HALTED;
                cntInc    = 1'b1;
            end else begin
                pcNext = targetPc;
                cntInc = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= ST_RUN;
            PC         <= RESET_PC;
            InstrCount <= '0;
            BadAddr    <= '0;
        end else begin
            state <= stateNext;
            PC    <= pcNext;
            if (cntInc)
                InstrCount <= InstrCount + CNT_W'(1);
            if (trap)
                BadAddr <= RegTarget;
        end
    end

    assign FetchValid = (state == ST_RUN);
    assign Halted     = (state == ST_HALTED);
    assign AddrError  = (state == ST_ERROR);

endmodule
